// File: rtl/qc_perm_pkg.sv
// Shared constants and index helper for the QC-LDPC permutation network.
// Mode bit positions and the divider-free circulant index.
package qc_perm_pkg;

    localparam int MODE_GREV = 0;
    localparam int MODE_ROT  = 1;

    // (i + s) mod z, valid only while i < z and s < z so one subtract suffices.
    function automatic int rot_idx(input int i, input int s, input int z);
        int t;
        t = i + s;
        return (t >= z) ? t - z : t;
    endfunction

endpackage

// File: rtl/qc_rotate_group.sv
// One Z-lane circulant rotator: out[i] = in[(i+shift) mod Z]; zeroes the group on shift >= Z.
// Purely combinational; the enclosing pipeline stage registers the result.
module qc_rotate_group #(
    parameter int DATA_WIDTH = 6,
    parameter int Z          = 6,
    parameter int SW         = $clog2(Z)
) (
    input  logic                  rot_en,
    input  logic [SW-1:0]         shift,
    input  logic [DATA_WIDTH-1:0] din  [0:Z-1],
    output logic [DATA_WIDTH-1:0] dout [0:Z-1],
    output logic                  shift_err
);
    import qc_perm_pkg::*;

    logic shift_ok;

    assign shift_ok  = int'(shift) < Z;
    assign shift_err = rot_en && !shift_ok;

    always_comb begin
        for (int i = 0; i < Z; i++) begin
            dout[i] = '0;
            if (!rot_en) begin
                dout[i] = din[i];
            end else if (shift_ok) begin
                dout[i] = din[SW'(rot_idx(i, int'(shift), Z))];
            end
        end
    end

endmodule

// File: rtl/qc_perm_shuffle.sv
// Two-stage VNU/CNU permutation: group reverse, then per-group circulant rotate; 2-cycle latency.
// Valid/ready with per-stage enables; a stalled output holds both stages without dropping beats.
module qc_perm_shuffle #(
    parameter int DATA_WIDTH = 6,
    parameter int Z          = 6,
    parameter int NG         = 6,
    parameter int SW         = $clog2(Z)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            mode,
    input  logic [SW-1:0]         shift    [0:NG-1],
    input  logic [DATA_WIDTH-1:0] data_in  [0:NG*Z-1],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out [0:NG*Z-1],
    output logic                  err_shift
);
    import qc_perm_pkg::*;

    localparam int N = NG * Z;

    logic                  en1, en2;
    logic                  s1_valid;
    logic                  s1_rot;
    logic [SW-1:0]         s1_shift [0:NG-1];
    logic [DATA_WIDTH-1:0] s1_dat   [0:N-1];
    logic [DATA_WIDTH-1:0] s1_nxt   [0:N-1];
    logic [DATA_WIDTH-1:0] rot_dat  [0:N-1];
    logic [NG-1:0]         grp_err;

    assign en2      = !out_valid || out_ready;
    assign en1      = !s1_valid || en2;
    assign in_ready = en1;

    for (genvar g = 0; g < NG; g++) begin : g_grp
        logic [DATA_WIDTH-1:0] grp_in  [0:Z-1];
        logic [DATA_WIDTH-1:0] grp_out [0:Z-1];

        for (genvar i = 0; i < Z; i++) begin : g_lane
            assign s1_nxt[g*Z+i] = mode[MODE_GREV] ? data_in[(NG-1-g)*Z+i] : data_in[g*Z+i];
            assign grp_in[i]      = s1_dat[g*Z+i];
            assign rot_dat[g*Z+i] = grp_out[i];
        end

        qc_rotate_group #(
            .DATA_WIDTH(DATA_WIDTH),
            .Z         (Z),
            .SW        (SW)
        ) u_rot (
            .rot_en   (s1_rot),
            .shift    (s1_shift[g]),
            .din      (grp_in),
            .dout     (grp_out),
            .shift_err(grp_err[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_rot   <= 1'b0;
            for (int k = 0; k < N; k++)  s1_dat[k]   <= '0;
            for (int g = 0; g < NG; g++) s1_shift[g] <= '0;
        end else if (en1) begin
            s1_valid <= in_valid;
            s1_rot   <= mode[MODE_ROT];
            for (int k = 0; k < N; k++)  s1_dat[k]   <= s1_nxt[k];
            for (int g = 0; g < NG; g++) s1_shift[g] <= shift[g];
        end
    end

    // err_shift is flagged as the offending beat moves into the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            err_shift <= 1'b0;
            for (int k = 0; k < N; k++) data_out[k] <= '0;
        end else begin
            if (en2) begin
                out_valid <= s1_valid;
                for (int k = 0; k < N; k++) data_out[k] <= rot_dat[k];
            end
            if (en2 && s1_valid && |grp_err) begin
                err_shift <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qc_perm_shuffle.sv
// Directed bench for qc_perm_shuffle: vector table at NG=Z=6, streaming/stall/reset sequences,
// and a second instance at Z=5, NG=3 for the out-of-range shift corner.
module tb_qc_perm_shuffle;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       in_valid, in_ready, out_valid, out_ready, err_shift;
    logic [1:0] mode;
    logic [2:0] shift    [0:5];
    logic [5:0] data_in  [0:35];
    logic [5:0] data_out [0:35];

    logic       in_valid5, in_ready5, out_valid5, out_ready5, err5;
    logic [1:0] mode5;
    logic [2:0] shift5    [0:2];
    logic [5:0] data_in5  [0:14];
    logic [5:0] data_out5 [0:14];

    int tests = 0;
    int fails = 0;

    qc_perm_shuffle #(.DATA_WIDTH(6), .Z(6), .NG(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .shift(shift), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .err_shift(err_shift)
    );

    qc_perm_shuffle #(.DATA_WIDTH(6), .Z(5), .NG(3)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
        .mode(mode5), .shift(shift5), .data_in(data_in5),
        .out_valid(out_valid5), .out_ready(out_ready5), .data_out(data_out5),
        .err_shift(err5)
    );

    typedef struct {
        logic [1:0] mode;
        int         shift [0:5];
        int         exp   [0:35];
        int         exp_err;
    } vec_t;

    vec_t vecs [0:6];

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Single beat, out_ready held high: accept on the first edge, output after the second.
    task automatic send6(input int idx);
        @(negedge clk);
        mode = vecs[idx].mode;
        for (int g = 0; g < 6; g++)  shift[g]   = 3'(vecs[idx].shift[g]);
        for (int k = 0; k < 36; k++) data_in[k] = 6'(k);
        in_valid = 1'b1;
        #1 chk($sformatf("v%0d in_ready", idx), int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("v%0d early out_valid", idx), int'(out_valid), 0);
        @(negedge clk);
        chk($sformatf("v%0d out_valid", idx), int'(out_valid), 1);
        for (int k = 0; k < 36; k++)
            chk($sformatf("v%0d lane%0d", idx, k), int'(data_out[k]), vecs[idx].exp[k]);
        chk($sformatf("v%0d err_shift", idx), int'(err_shift), vecs[idx].exp_err);
    endtask

    task automatic send5(input string name, input logic [1:0] m, input int s0, input int s1,
                         input int s2, input int e [0:14], input int e_err);
        @(negedge clk);
        mode5 = m;
        shift5[0] = 3'(s0); shift5[1] = 3'(s1); shift5[2] = 3'(s2);
        for (int k = 0; k < 15; k++) data_in5[k] = 6'(k);
        in_valid5 = 1'b1;
        @(negedge clk);
        in_valid5 = 1'b0;
        @(negedge clk);
        chk({name, " out_valid"}, int'(out_valid5), 1);
        for (int k = 0; k < 15; k++)
            chk($sformatf("%s lane%0d", name, k), int'(data_out5[k]), e[k]);
        chk({name, " err_shift"}, int'(err5), e_err);
    endtask

    // Ten beats in mode 01 with a varying out_ready; every output is checked against a scoreboard.
    task automatic run_stream(input bit rnd);
        int         exp_q [$];
        int         sent = 0;
        int         got  = 0;
        bit         acc  = 0;
        bit         hold = 0;
        logic [5:0] snap [0:35];
        for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
            @(negedge clk);
            if (acc) in_valid = 1'b0;
            acc = 0;
            out_ready = rnd ? ($urandom_range(0, 1) == 1) : ((cyc % 2) == 1);
            if (!in_valid && sent < 10 && (!rnd || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                mode     = 2'b01;
                for (int k = 0; k < 36; k++) data_in[k] = 6'(sent * 5 + k);
            end
            #1;
            if (hold) begin
                int diff = 0;
                for (int k = 0; k < 36; k++) if (data_out[k] != snap[k]) diff++;
                chk("stall out_valid held", int'(out_valid), 1);
                chk("stall data_out stable lanes changed", diff, 0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream unexpected beat", 1, 0);
                end else begin
                    int tag = exp_q.pop_front();
                    int bad = 0;
                    for (int k = 0; k < 36; k++)
                        if (int'(data_out[k]) != ((tag * 5 + (5 - k / 6) * 6 + k % 6) & 63)) bad++;
                    chk($sformatf("stream beat%0d bad lanes", tag), bad, 0);
                end
                got++;
            end
            hold = out_valid && !out_ready;
            if (hold) for (int k = 0; k < 36; k++) snap[k] = data_out[k];
            if (in_valid && in_ready) begin
                exp_q.push_back(sent);
                sent++;
                acc = 1;
            end
        end
        chk("stream beats out", got, 10);
        chk("stream beats left", exp_q.size(), 0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int e5a [0:14];
        int e5b [0:14];
        int e5c [0:14];
        int vcnt;

        vecs[0].mode = 2'b00; vecs[0].shift = '{0, 0, 0, 0, 0, 0}; vecs[0].exp_err = 0;
        vecs[0].exp  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17,
                         18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 32, 33, 34, 35};
        vecs[1].mode = 2'b01; vecs[1].shift = '{0, 0, 0, 0, 0, 0}; vecs[1].exp_err = 0;
        vecs[1].exp  = '{30, 31, 32, 33, 34, 35, 24, 25, 26, 27, 28, 29, 18, 19, 20, 21, 22, 23,
                         12, 13, 14, 15, 16, 17, 6, 7, 8, 9, 10, 11, 0, 1, 2, 3, 4, 5};
        vecs[2].mode = 2'b10; vecs[2].shift = '{0, 1, 2, 3, 4, 5}; vecs[2].exp_err = 0;
        vecs[2].exp  = '{0, 1, 2, 3, 4, 5, 7, 8, 9, 10, 11, 6, 14, 15, 16, 17, 12, 13,
                         21, 22, 23, 18, 19, 20, 28, 29, 24, 25, 26, 27, 35, 30, 31, 32, 33, 34};
        vecs[3].mode = 2'b10; vecs[3].shift = '{5, 5, 5, 5, 5, 5}; vecs[3].exp_err = 0;
        vecs[3].exp  = '{5, 0, 1, 2, 3, 4, 11, 6, 7, 8, 9, 10, 17, 12, 13, 14, 15, 16,
                         23, 18, 19, 20, 21, 22, 29, 24, 25, 26, 27, 28, 35, 30, 31, 32, 33, 34};
        vecs[4].mode = 2'b01; vecs[4].shift = '{7, 7, 7, 7, 7, 7}; vecs[4].exp_err = 0;
        vecs[4].exp  = vecs[1].exp;
        vecs[5].mode = 2'b11; vecs[5].shift = '{1, 1, 1, 1, 1, 1}; vecs[5].exp_err = 0;
        vecs[5].exp  = '{31, 32, 33, 34, 35, 30, 25, 26, 27, 28, 29, 24, 19, 20, 21, 22, 23, 18,
                         13, 14, 15, 16, 17, 12, 7, 8, 9, 10, 11, 6, 1, 2, 3, 4, 5, 0};
        vecs[6].mode = 2'b11; vecs[6].shift = '{1, 1, 7, 1, 1, 1}; vecs[6].exp_err = 1;
        vecs[6].exp  = '{31, 32, 33, 34, 35, 30, 25, 26, 27, 28, 29, 24, 0, 0, 0, 0, 0, 0,
                         13, 14, 15, 16, 17, 12, 7, 8, 9, 10, 11, 6, 1, 2, 3, 4, 5, 0};

        e5a = '{4, 0, 1, 2, 3, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
        e5b = '{14, 10, 11, 12, 13, 5, 6, 7, 8, 9, 3, 4, 0, 1, 2};
        e5c = '{4, 0, 1, 2, 3, 0, 0, 0, 0, 0, 10, 11, 12, 13, 14};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00;
        in_valid5 = 1'b0; out_ready5 = 1'b1; mode5 = 2'b00;
        for (int g = 0; g < 6; g++)  shift[g]    = '0;
        for (int g = 0; g < 3; g++)  shift5[g]   = '0;
        for (int k = 0; k < 36; k++) data_in[k]  = '0;
        for (int k = 0; k < 15; k++) data_in5[k] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset err_shift", int'(err_shift), 0);
        chk("reset data_out[0]", int'(data_out[0]), 0);
        chk("reset data_out[35]", int'(data_out[35]), 0);
        chk("reset err_shift z5", int'(err5), 0);

        for (int v = 0; v < 7; v++) send6(v);
        repeat (3) @(negedge clk);
        chk("err_shift sticky", int'(err_shift), 1);

        run_stream(1'b0);
        run_stream(1'b1);

        // Fill both stages with out_ready low, then reset with two beats in flight.
        @(negedge clk);
        out_ready = 1'b0; mode = 2'b00; in_valid = 1'b1;
        for (int k = 0; k < 36; k++) data_in[k] = 6'(40);
        @(negedge clk);
        for (int k = 0; k < 36; k++) data_in[k] = 6'(41);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("full in_ready", int'(in_ready), 0);
        chk("full out_valid", int'(out_valid), 1);
        chk("full holds first beat", int'(data_out[0]), 40);
        out_ready = 1'b1;
        #1 chk("in_ready follows out_ready", int'(in_ready), 1);
        out_ready = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midreset out_valid", int'(out_valid), 0);
        chk("midreset err_shift", int'(err_shift), 0);
        chk("midreset in_ready", int'(in_ready), 1);
        vcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        chk("midreset beats emitted", vcnt, 0);

        send5("z5 shift4", 2'b10, 4, 0, 0, e5a, 0);
        send5("z5 rev shift", 2'b11, 4, 0, 3, e5b, 0);
        send5("z5 shift5", 2'b10, 4, 5, 0, e5c, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
